// File: rtl/tone_pkg.sv
// Shared definitions for the keypad tone generator and the tone pitch detector:
// note period table, key encodings and detector state encoding.
package tone_pkg;

    localparam int NUM_KEYS = 12;
    localparam logic [3:0] KEY_NONE = 4'd0;

    // Full tone period in sys_clk cycles for keys 1..12 (index 0 = key 1).
    localparam int unsigned TONE_PERIOD [NUM_KEYS] = '{
        381678, 340136, 303030, 286532, 255102, 227272,
        202428, 191204, 170358, 151744, 143266, 127550
    };

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2,
        ST_LOCKED  = 2'd3
    } det_state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// rising-edge pulse (pulse appears on the third clock after the input rises).
module edge_sync (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic meta;
    logic sync_d;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
            sync_d   <= 1'b0;
            rise     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge
            // value, which is what keeps this a real shift chain.
            meta     <= async_in;
            sync_out <= meta;
            sync_d   <= sync_out;
            rise     <= sync_out & ~sync_d;
        end
    end

endmodule

// File: rtl/tone_pitch_dtctr.sv
// Tone pitch detector: measures the period of a square-wave tone in sys_clk
// cycles and reports the matching key once two consecutive periods agree.
module tone_pitch_dtctr
    import tone_pkg::*;
#(
    parameter int CNT_W        = 20,
    parameter int TOL          = 2000,
    parameter int TIMEOUT      = 400_000,
    // Divides every note period by 2**PERIOD_SHIFT (instances on a slower sys_clk).
    parameter int PERIOD_SHIFT = 0
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             tone_in,
    output logic [3:0]       key_code,
    output logic             key_valid,
    output logic             key_change,
    output logic [CNT_W-1:0] period_out
);

    localparam logic [CNT_W:0] TIMEOUT_C = (CNT_W+1)'(TIMEOUT);
    localparam logic [CNT_W:0] TOL_C     = (CNT_W+1)'(TOL);
    localparam logic [CNT_W:0] ONE_C     = (CNT_W+1)'(1);

    // Window match against all notes; the lowest key number wins on overlap.
    function automatic logic [3:0] classify(input logic [CNT_W:0] c);
        logic [CNT_W:0] p;
        logic [CNT_W:0] diff;
        logic [3:0]     k;
        k = KEY_NONE;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            p    = (CNT_W+1)'(TONE_PERIOD[i] >> PERIOD_SHIFT);
            diff = (c >= p) ? (c - p) : (p - c);
            if (diff <= TOL_C) k = 4'(i + 1);
        end
        return k;
    endfunction

    logic           tone_sync_unused;
    logic           edge_hit;
    logic [CNT_W:0] cnt;
    logic [3:0]     cls;
    logic           tmo;

    det_state_t state, state_nxt;
    logic [3:0] cand, cand_nxt;
    logic [3:0] key_nxt;
    logic       valid_nxt;

    edge_sync u_edge_sync (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .async_in (tone_in),
        .sync_out (tone_sync_unused),
        .rise     (edge_hit)
    );

    assign cls = classify(cnt);
    // An edge landing on the saturated count is a period, not a timeout.
    assign tmo = (cnt == TIMEOUT_C) && !edge_hit;

    always_comb begin
        // NOTE: every output of this block is given a default first so no path
        // leaves one unassigned, which would infer a latch.
        state_nxt = state;
        cand_nxt  = cand;
        key_nxt   = key_code;
        valid_nxt = key_valid;
        if (edge_hit) begin
            case (state)
                ST_IDLE:  state_nxt = ST_ARMED;
                ST_ARMED: begin
                    state_nxt = ST_MEASURE;
                    cand_nxt  = cls;
                end
                ST_MEASURE: begin
                    if (cls == cand) begin
                        state_nxt = ST_LOCKED;
                        key_nxt   = cls;
                        valid_nxt = (cls != KEY_NONE);
                    end else begin
                        cand_nxt = cls;
                    end
                end
                ST_LOCKED: begin
                    if (cls != key_code) begin
                        state_nxt = ST_MEASURE;
                        cand_nxt  = cls;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end else if (tmo && (state != ST_IDLE)) begin
            state_nxt = ST_IDLE;
            cand_nxt  = KEY_NONE;
            key_nxt   = KEY_NONE;
            valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= ST_IDLE;
            cand       <= KEY_NONE;
            cnt        <= '0;
            key_code   <= KEY_NONE;
            key_valid  <= 1'b0;
            key_change <= 1'b0;
            period_out <= '0;
        end else begin
            state      <= state_nxt;
            cand       <= cand_nxt;
            key_code   <= key_nxt;
            key_valid  <= valid_nxt;
            key_change <= (key_nxt != key_code);
            if (edge_hit) begin
                cnt <= ONE_C;
                // The arming edge has no preceding reference, so no period yet.
                if (state != ST_IDLE) period_out <= cnt[CNT_W-1:0];
            end else if (cnt != TIMEOUT_C) begin
                cnt <= cnt + ONE_C;
            end
        end
    end

endmodule
